// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: the carry chain is cut into STAGES segments of SEG bits,
// one segment resolved per clock, with a global valid/ready stall.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             en;
  logic [WIDTH-1:0] b_eff;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             cy_q  [STAGES];
  logic             v_q   [STAGES];

  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             cy_in [STAGES];
  logic             cy_nxt[STAGES];
  logic             v_in  [STAGES];

  logic [SEG:0]     seg_res;
  logic             ovf_nxt;
  logic             zero_nxt;
  logic             ovf_q;
  logic             zero_q;

  assign en       = !v_q[LAST] || out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;

  // Stage k takes its operands from stage k-1 (stage 0 from the ports) and
  // resolves only its own SEG-bit slice; lower slices are passed through.
  always_comb begin
    seg_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_in[k]  = a;
        b_in[k]  = b_eff;
        s_in[k]  = '0;
        cy_in[k] = c_in;
        v_in[k]  = in_valid;
      end else begin
        a_in[k]  = a_q[(k == 0) ? 0 : k - 1];
        b_in[k]  = b_q[(k == 0) ? 0 : k - 1];
        s_in[k]  = s_q[(k == 0) ? 0 : k - 1];
        cy_in[k] = cy_q[(k == 0) ? 0 : k - 1];
        v_in[k]  = v_q[(k == 0) ? 0 : k - 1];
      end
      seg_res = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, cy_in[k]};
      s_nxt[k] = s_in[k];
      s_nxt[k][k*SEG +: SEG] = seg_res[SEG-1:0];
      cy_nxt[k] = seg_res[SEG];
    end
    ovf_nxt  = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
               (s_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
    zero_nxt = (s_nxt[LAST] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        cy_q[k] <= 1'b0;
        v_q[k]  <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= a_in[k];
        b_q[k]  <= b_in[k];
        s_q[k]  <= s_nxt[k];
        cy_q[k] <= cy_nxt[k];
        v_q[k]  <= v_in[k];
      end
      ovf_q  <= ovf_nxt;
      zero_q <= zero_nxt;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign c_out     = cy_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
